// File: rtl/garage_door_ctrl.sv
// garage_door_ctrl: single-door opener. Drives the open/close motors from a
// debounced Activate button and the two limit switches. Adds stop/resume,
// obstacle auto-reverse while closing, a travel timeout and a limit-switch
// consistency check. Both timeout and limit faults are sticky until RST.
//
// Build option: DIR_GAP_EN - when defined, an obstacle reversal passes through
// REV_WAIT (both motors off for GAP_CYCLES cycles) before opening. When
// undefined, closing turns directly into opening on the same edge.
//
// state    | meaning
// IDLE     | motors off, waiting for an Activate edge
// MV_UP    | opening (UP_M on)
// MV_DN    | closing (DN_M on)
// STOPPED  | halted mid-travel, next edge resumes in the opposite direction
// FAULT    | motors off, sticky until RST
// REV_WAIT | dead time before an obstacle reversal (DIR_GAP_EN only)
module garage_door_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16,
  parameter int GAP_CYCLES     = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Activate,
  input  logic       Up_MAX,
  input  logic       Dn_MAX,
  input  logic       Obstacle,
  output logic       UP_M,
  output logic       DN_M,
  output logic       Fault,
  output logic [2:0] Door_State
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MV_UP    = 3'd1,
    S_MV_DN    = 3'd2,
    S_STOPPED  = 3'd3,
`ifdef DIR_GAP_EN
    S_FAULT    = 3'd4,
    S_REV_WAIT = 3'd5
`else
    S_FAULT    = 3'd4
`endif
  } state_t;

  // Parameter sanity: the counter must be able to reach both terminal counts.
  if (TIMEOUT_CYCLES < 1 || (TIMEOUT_CYCLES >> CNT_W) != 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1 and fit in CNT_W bits");
  end
  if (GAP_CYCLES < 1 || (GAP_CYCLES >> CNT_W) != 0) begin : g_bad_gap
    $error("GAP_CYCLES must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef DIR_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_dir, last_dir_nxt;   // 1 = was opening when stopped
  logic             act_q;
  logic             act_pulse;
  logic             limits_bad;
  logic             timeout;

  assign act_pulse  = Activate & ~act_q;
  assign limits_bad = Up_MAX & Dn_MAX;
  assign timeout    = (cnt == TO_LAST);

  // Next-state, travel/gap counter and stop-direction decode.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = '0;
    last_dir_nxt = last_dir;
    unique case (state)
      S_IDLE: begin
        if (act_pulse) begin
          // Only "fully open" sends the door down; closed or mid-way opens it.
          if (Up_MAX && !Dn_MAX) state_nxt = S_MV_DN;
          else                   state_nxt = S_MV_UP;
        end
      end
      S_MV_UP: begin
        if (Up_MAX)         state_nxt = S_IDLE;
        else if (timeout)   state_nxt = S_FAULT;
        else if (act_pulse) begin
          state_nxt    = S_STOPPED;
          last_dir_nxt = 1'b1;
        end else            cnt_nxt = cnt + 1'b1;
      end
      S_MV_DN: begin
        if (Dn_MAX)         state_nxt = S_IDLE;
        else if (Obstacle) begin
`ifdef DIR_GAP_EN
          state_nxt = S_REV_WAIT;
`else
          state_nxt = S_MV_UP;
`endif
        end
        else if (timeout)   state_nxt = S_FAULT;
        else if (act_pulse) begin
          state_nxt    = S_STOPPED;
          last_dir_nxt = 1'b0;
        end else            cnt_nxt = cnt + 1'b1;
      end
      S_STOPPED: begin
        if (act_pulse) begin
          // Never start closing into a blocked beam.
          if (last_dir) begin
            if (!Obstacle) state_nxt = S_MV_DN;
          end else begin
            state_nxt = S_MV_UP;
          end
        end
      end
`ifdef DIR_GAP_EN
      S_REV_WAIT: begin
        if (cnt == GAP_LAST) state_nxt = S_MV_UP;
        else                 cnt_nxt   = cnt + 1'b1;
      end
`endif
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_FAULT;
    endcase
    // Both limits active at once is physically impossible: wiring/sensor fault.
    if (state != S_FAULT && limits_bad) begin
      state_nxt = S_FAULT;
      cnt_nxt   = '0;
    end
  end

  // State, counter and registered Moore outputs; motors drop as soon as RST rises.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last_dir <= 1'b0;
      act_q    <= 1'b0;
      UP_M     <= 1'b0;
      DN_M     <= 1'b0;
      Fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_dir <= last_dir_nxt;
      act_q    <= Activate;
      UP_M     <= (state_nxt == S_MV_UP);
      DN_M     <= (state_nxt == S_MV_DN);
      Fault    <= (state_nxt == S_FAULT);
    end
  end

  assign Door_State = state;

endmodule

// File: doc/garage_door_ctrl.md
Name: garage_door_ctrl

Overview:
Parametrised successor to the single-door Activate/limit-switch controller. It drives the UP_M/DN_M motor outputs from an Activate push-button and the Up_MAX/Dn_MAX limit switches. It adds:
- stop-in-travel and resume in the opposite direction;
- obstacle auto-reverse while closing;
- travel-timeout fault detection;
- limit-sensor consistency fault detection.

It sits between the debounced button/sensor inputs and the motor driver.

Parameters:
TIMEOUT_CYCLES, 1000, maximum consecutive cycles a motor output may stay asserted before FAULT.
CNT_W, 16, width of travel counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
GAP_CYCLES, 4, motor-off dead time before an obstacle reversal (used only with DIR_GAP_EN).

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-high reset.
Activate  input  1  push-button level; only its rising edge acts.
Up_MAX  input  1  door fully open limit switch.
Dn_MAX  input  1  door fully closed limit switch.
Obstacle  input  1  beam-break sensor, 1 = obstructed.
UP_M  output  1  open motor drive.
DN_M  output  1  close motor drive.
Fault  output  1  sticky fault flag.
Door_State  output  3  state encoding: 0 IDLE, 1 MV_UP, 2 MV_DN, 3 STOPPED, 4 FAULT, 5 REV_WAIT.

Behaviour:
- Reset value of every output is 0. State is IDLE, travel counter 0, last_dir = down, act_q = 0.
- Edge detect: act_q <= Activate each cycle; act_pulse = Activate & ~act_q. A held Activate produces exactly one pulse.
- Outputs are Moore, decoded from the state register:
  - UP_M = (state == MV_UP); DN_M = (state == MV_DN); Fault = (state == FAULT).
  - UP_M and DN_M are never 1 together.
- Response latency: the state change is visible on outputs 1 cycle after the causing input is sampled.
- Sensor fault: Up_MAX & Dn_MAX sampled high in any non-FAULT state -> FAULT. This has top priority.
- IDLE, on act_pulse:
  - Dn_MAX only -> MV_UP.
  - Up_MAX only -> MV_DN.
  - Neither limit -> MV_UP (mid-position power-up).
- MV_UP, priority Up_MAX > timeout > act_pulse:
  - Up_MAX -> IDLE.
  - Timeout -> FAULT.
  - act_pulse -> STOPPED with last_dir = up.
- MV_DN, priority Dn_MAX > Obstacle > timeout > act_pulse:
  - Dn_MAX -> IDLE.
  - Obstacle -> MV_UP (or REV_WAIT with the macro).
  - Timeout -> FAULT.
  - act_pulse -> STOPPED with last_dir = down.
- STOPPED (motors off, no timeout), on act_pulse:
  - last_dir = up -> MV_DN. If Obstacle is 1 on the same cycle, remain in STOPPED.
  - last_dir = down -> MV_UP.
- FAULT: all motors off; sticky, left only via RST.
- Travel counter:
  - Clears to 0 on every entry into MV_UP/MV_DN, including a direct reversal MV_DN->MV_UP.
  - Increments each cycle in a move state.
  - Timeout = counter == TIMEOUT_CYCLES-1 with no terminating limit, so a motor is high for at most TIMEOUT_CYCLES cycles.
  - Holds 0 outside move states.
- Reset mid-travel: motors drop asynchronously on RST assertion. After release the block is in IDLE and needs a fresh Activate edge.
- Obstacle is ignored in IDLE, MV_UP and FAULT.

Optional Feature:
Macro DIR_GAP_EN.
- Defined: an obstacle in MV_DN goes to REV_WAIT. Both motors are off there for exactly GAP_CYCLES cycles (gap counter reuses the travel counter), then the block enters MV_UP. The sensor fault check still applies in REV_WAIT; act_pulse is ignored there.
- Undefined: REV_WAIT does not exist; MV_DN -> MV_UP directly (DN_M falls and UP_M rises on the same edge). Encoding 5 is unused.

Test Plan:
- Reset, Dn_MAX=1, pulse Activate for 1 cycle -> UP_M=1 next cycle. Set Up_MAX=1 after 3 cycles -> UP_M=0, Door_State=0 the following cycle.
- Up_MAX=1, Activate held high for 5 cycles -> exactly one MV_DN entry, DN_M=1. Set Dn_MAX=1 -> DN_M=0 and IDLE.
- While in MV_DN, Activate edge -> STOPPED (Door_State=3, both motors 0). Next Activate edge -> UP_M=1. With Obstacle=1 and last_dir=up, an Activate edge -> stays STOPPED.
- MV_DN with Obstacle=1 -> UP_M=1 one cycle later (undefined macro), or after GAP_CYCLES=4 motor-off cycles in Door_State=5 (DIR_GAP_EN).
- TIMEOUT_CYCLES=8, start MV_UP with no limit -> UP_M high exactly 8 cycles, then Fault=1, Door_State=4; Activate is ignored until RST.
- Up_MAX=Dn_MAX=1 in IDLE -> Fault=1 next cycle. RST asserted mid-MV_UP -> UP_M=0 immediately (asynchronous), Door_State=0.
